// File: rtl/mvm_pkg.sv
// Shared definitions for the dense-layer scheduler: CPU register map, engine register map, FSM states.
package mvm_pkg;

    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_BIAS   = 4'd1;
    localparam logic [3:0] REG_WEIGHT = 4'd2;
    localparam logic [3:0] REG_INPUT  = 4'd3;
    localparam logic [3:0] REG_OUTPUT = 4'd4;
    localparam logic [3:0] REG_NIN    = 4'd5;
    localparam logic [3:0] REG_NOUT   = 4'd6;
    localparam logic [3:0] REG_RELU   = 4'd7;

    localparam logic [3:0] DOT_START = 4'd0;
    localparam logic [3:0] DOT_WPTR  = 4'd2;
    localparam logic [3:0] DOT_IPTR  = 4'd3;
    localparam logic [3:0] DOT_LEN   = 4'd5;

    typedef enum logic [3:0] {
        StIdle,
        StCfgW,
        StCfgI,
        StCfgN,
        StStart,
        StResult,
        StAct,
        StWrite,
        StNext
    } state_e;

endpackage

// File: rtl/avm_word_reader.sv
// Single-word Avalon-MM read: request held through waitrequest, data captured on readdatavalid,
// then a one-cycle done pulse with the captured word.
module avm_word_reader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] addr,
    output logic [31:0] address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic        readdatavalid,
    output logic [31:0] data,
    output logic        done
);

    typedef enum logic [1:0] {RdIdle, RdReq, RdWait} rd_state_e;

    rd_state_e   state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        done_q;

    always_comb begin
        state_d = state_q;
        read    = 1'b0;
        unique case (state_q)
            RdIdle: if (start) state_d = RdReq;
            RdReq: begin
                read = 1'b1;
                if (!waitrequest) state_d = RdWait;
            end
            RdWait: if (readdatavalid) state_d = RdIdle;
            default: state_d = RdIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RdIdle;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == RdWait) && readdatavalid;
            if (state_q == RdIdle && start) addr_q <= addr;
            if (state_q == RdWait && readdatavalid) data_q <= readdata;
        end
    end

    assign address = addr_q;
    assign data    = data_q;
    assign done    = done_q;

endmodule

// File: rtl/mvm_layer_sched.sv
// Row-by-row scheduler for y = act(W*x + b): reprograms the dot engine per row, fetches the bias
// from SDRAM in parallel with the engine, adds it, optionally clamps at zero and stores to SRAM.
module mvm_layer_sched
    import mvm_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    output logic [31:0] slave_readdata,
    input  logic [31:0] slave_writedata,
    input  logic        dot_waitrequest,
    output logic [3:0]  dot_address,
    output logic        dot_read,
    output logic        dot_write,
    output logic [31:0] dot_writedata,
    input  logic [31:0] dot_readdata,
    output logic [31:0] master_address,
    output logic        master_read,
    output logic        master_write,
    input  logic        master_waitrequest,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic [31:0] master2_address,
    output logic        master2_read,
    output logic        master2_write,
    output logic [31:0] master2_writedata,
    input  logic        master2_waitrequest
);

    state_e      state_q, state_d;
    logic [31:0] bias_base_q, weight_base_q, input_base_q, output_base_q;
    logic [31:0] n_in_q, n_out_q;
    logic        relu_en_q;
    logic [31:0] w_ptr_q, b_ptr_q, o_ptr_q, rows_done_q;
    logic [31:0] result_q, bias_q, acc_q;
    logic        res_have_q, bias_have_q, bias_kick_q;

    logic        start_job, row_start, last_row;
    logic [31:0] sum, bias_data;
    logic        bias_done;
    state_e      row_first;
    logic        unused_read;

    assign unused_read = slave_read;
    assign start_job   = (state_q == StIdle) && slave_write && (slave_address == REG_CTRL);
    assign last_row    = (rows_done_q + 32'd1) == n_out_q;
    assign row_first   = (n_in_q == 32'd0) ? StResult : StCfgW;
    assign row_start   = (start_job && n_out_q != 32'd0) || (state_q == StNext && !last_row);
    assign sum         = result_q + bias_q;

    always_comb begin
        state_d           = state_q;
        slave_waitrequest = (state_q != StIdle);
        dot_address       = DOT_START;
        dot_read          = 1'b0;
        dot_write         = 1'b0;
        dot_writedata     = '0;
        master2_write     = 1'b0;
        unique case (state_q)
            StIdle: if (start_job && n_out_q != 32'd0) state_d = row_first;
            StCfgW: begin
                dot_write     = 1'b1;
                dot_address   = DOT_WPTR;
                dot_writedata = w_ptr_q;
                if (!dot_waitrequest) state_d = StCfgI;
            end
            StCfgI: begin
                dot_write     = 1'b1;
                dot_address   = DOT_IPTR;
                dot_writedata = input_base_q;
                if (!dot_waitrequest) state_d = StCfgN;
            end
            StCfgN: begin
                dot_write     = 1'b1;
                dot_address   = DOT_LEN;
                dot_writedata = n_in_q;
                if (!dot_waitrequest) state_d = StStart;
            end
            StStart: begin
                dot_write     = 1'b1;
                dot_address   = DOT_START;
                dot_writedata = 32'd1;
                if (!dot_waitrequest) state_d = StResult;
            end
            // Wait here for both the engine sum and the overlapped bias fetch.
            StResult: begin
                dot_read = !res_have_q;
                if (res_have_q && bias_have_q) state_d = StAct;
            end
            StAct: state_d = StWrite;
            StWrite: begin
                master2_write = 1'b1;
                if (!master2_waitrequest) state_d = StNext;
            end
            StNext: state_d = last_row ? StIdle : row_first;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            bias_base_q   <= '0;
            weight_base_q <= '0;
            input_base_q  <= '0;
            output_base_q <= '0;
            n_in_q        <= '0;
            n_out_q       <= '0;
            relu_en_q     <= 1'b0;
            w_ptr_q       <= '0;
            b_ptr_q       <= '0;
            o_ptr_q       <= '0;
            rows_done_q   <= '0;
            result_q      <= '0;
            bias_q        <= '0;
            acc_q         <= '0;
            res_have_q    <= 1'b0;
            bias_have_q   <= 1'b0;
            bias_kick_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bias_kick_q <= row_start;
            if (state_q == StIdle && slave_write) begin
                unique case (slave_address)
                    REG_CTRL: begin
                        w_ptr_q     <= weight_base_q;
                        b_ptr_q     <= bias_base_q;
                        o_ptr_q     <= output_base_q;
                        rows_done_q <= '0;
                    end
                    REG_BIAS:   bias_base_q   <= slave_writedata;
                    REG_WEIGHT: weight_base_q <= slave_writedata;
                    REG_INPUT:  input_base_q  <= slave_writedata;
                    REG_OUTPUT: output_base_q <= slave_writedata;
                    REG_NIN:    n_in_q        <= slave_writedata;
                    REG_NOUT:   n_out_q       <= slave_writedata;
                    REG_RELU:   relu_en_q     <= slave_writedata[0];
                    default: ;
                endcase
            end
            // An empty row never touches the engine; its dot product is zero.
            if (row_start) begin
                res_have_q  <= (n_in_q == 32'd0);
                result_q    <= '0;
                bias_have_q <= 1'b0;
            end
            if (state_q == StResult && dot_read && !dot_waitrequest) begin
                result_q   <= dot_readdata;
                res_have_q <= 1'b1;
            end
            if (bias_done) begin
                bias_q      <= bias_data;
                bias_have_q <= 1'b1;
            end
            if (state_q == StAct) acc_q <= (relu_en_q && sum[31]) ? 32'd0 : sum;
            if (state_q == StNext) begin
                rows_done_q <= rows_done_q + 32'd1;
                w_ptr_q     <= w_ptr_q + 32'(WORD_BYTES) * n_in_q;
                b_ptr_q     <= b_ptr_q + 32'd4;
                o_ptr_q     <= o_ptr_q + 32'd4;
            end
        end
    end

    always_comb begin
        slave_readdata = '0;
        unique case (slave_address)
            REG_CTRL:   slave_readdata = rows_done_q;
            REG_BIAS:   slave_readdata = bias_base_q;
            REG_WEIGHT: slave_readdata = weight_base_q;
            REG_INPUT:  slave_readdata = input_base_q;
            REG_OUTPUT: slave_readdata = output_base_q;
            REG_NIN:    slave_readdata = n_in_q;
            REG_NOUT:   slave_readdata = n_out_q;
            REG_RELU:   slave_readdata = {31'd0, relu_en_q};
            default:    slave_readdata = '0;
        endcase
    end

    avm_word_reader u_bias_reader (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (bias_kick_q),
        .addr          (b_ptr_q),
        .address       (master_address),
        .read          (master_read),
        .waitrequest   (master_waitrequest),
        .readdata      (master_readdata),
        .readdatavalid (master_readdatavalid),
        .data          (bias_data),
        .done          (bias_done)
    );

    assign master_write      = 1'b0;
    assign master2_read      = 1'b0;
    assign master2_address   = o_ptr_q;
    assign master2_writedata = acc_q;

endmodule

// File: tb/tb_mvm_layer_sched.sv
// Directed bench for mvm_layer_sched with behavioural dot engine, SDRAM and SRAM models.
module tb_mvm_layer_sched;
    import mvm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read, slave_write;
    logic [31:0] slave_readdata, slave_writedata;
    logic        dot_waitrequest;
    logic [3:0]  dot_address;
    logic        dot_read, dot_write;
    logic [31:0] dot_writedata, dot_readdata;
    logic [31:0] master_address;
    logic        master_read, master_write, master_waitrequest;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic [31:0] master2_address, master2_writedata;
    logic        master2_read, master2_write, master2_waitrequest;

    always #5 clk = ~clk;

    mvm_layer_sched #(.WORD_BYTES(4)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_write          (slave_write),
        .slave_readdata       (slave_readdata),
        .slave_writedata      (slave_writedata),
        .dot_waitrequest      (dot_waitrequest),
        .dot_address          (dot_address),
        .dot_read             (dot_read),
        .dot_write            (dot_write),
        .dot_writedata        (dot_writedata),
        .dot_readdata         (dot_readdata),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_write         (master_write),
        .master_waitrequest   (master_waitrequest),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master2_address      (master2_address),
        .master2_read         (master2_read),
        .master2_write        (master2_write),
        .master2_writedata    (master2_writedata),
        .master2_waitrequest  (master2_waitrequest)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] sdram [0:255];
    logic [31:0] sram  [0:255];
    int stall_fixed = -1;

    function automatic int pick_stall();
        return (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, 2));
    endfunction

    function automatic logic [31:0] dot_model(input logic [31:0] wp, input logic [31:0] ip,
                                              input logic [31:0] len);
        longint acc = 0;
        logic [31:0] wv, xv;
        for (int i = 0; i < int'(len); i++) begin
            wv = sdram[(int'(wp) / 4 + i) % 256];
            xv = sdram[(int'(ip) / 4 + i) % 256];
            acc += (longint'($signed(wv)) * longint'($signed(xv))) >>> 16;
        end
        return acc[31:0];
    endfunction

    // Dot engine: busy after START, plus per-access stall.
    logic        d_pend, d_strobe, d_bus_wait, d_acc;
    int          d_cnt, d_nst, busy, len_writes;
    logic [31:0] e_wptr, e_iptr, e_len, e_sum;
    assign d_strobe        = dot_read | dot_write;
    assign d_bus_wait      = d_strobe && (d_pend ? (d_cnt != 0) : (d_nst != 0));
    assign dot_waitrequest = (busy != 0) || d_bus_wait;
    assign d_acc           = d_strobe && !dot_waitrequest;
    assign dot_readdata    = e_sum;

    always @(posedge clk) begin
        if (!rst_n) begin
            d_pend <= 1'b0; d_cnt <= 0; d_nst <= 0; busy <= 0;
            e_wptr <= '0; e_iptr <= '0; e_len <= '0; e_sum <= '0;
        end else begin
            if (busy != 0) busy <= busy - 1;
            else if (d_strobe) begin
                if (!d_pend) begin
                    if (d_nst == 0) d_nst <= pick_stall();
                    else begin d_pend <= 1'b1; d_cnt <= d_nst - 1; end
                end else if (d_cnt == 0) begin
                    d_pend <= 1'b0; d_nst <= pick_stall();
                end else d_cnt <= d_cnt - 1;
            end
            if (d_acc && dot_write) begin
                case (dot_address)
                    DOT_WPTR: e_wptr <= dot_writedata;
                    DOT_IPTR: e_iptr <= dot_writedata;
                    DOT_LEN: begin e_len <= dot_writedata; len_writes <= len_writes + 1; end
                    DOT_START: begin
                        e_sum <= dot_model(e_wptr, e_iptr, e_len);
                        busy  <= 2 + pick_stall();
                    end
                    default: ;
                endcase
            end
        end
    end

    // SDRAM read port with stall and 1-3 cycle read latency.
    logic        m_pend;
    int          m_cnt, m_nst, lat;
    logic [31:0] m_data;
    assign master_waitrequest = master_read && (m_pend ? (m_cnt != 0) : (m_nst != 0));

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pend <= 1'b0; m_cnt <= 0; m_nst <= 0; lat <= 0;
            master_readdatavalid <= 1'b0; master_readdata <= '0;
        end else begin
            master_readdatavalid <= 1'b0;
            if (lat == 1) begin master_readdatavalid <= 1'b1; master_readdata <= m_data; end
            if (lat != 0) lat <= lat - 1;
            if (master_read) begin
                if (!m_pend) begin
                    if (m_nst == 0) m_nst <= pick_stall();
                    else begin m_pend <= 1'b1; m_cnt <= m_nst - 1; end
                end else if (m_cnt == 0) begin
                    m_pend <= 1'b0; m_nst <= pick_stall();
                end else m_cnt <= m_cnt - 1;
            end
            if (master_read && !master_waitrequest) begin
                lat    <= 1 + int'($urandom_range(0, 2));
                m_data <= sdram[master_address[9:2]];
            end
        end
    end

    // SRAM write port with stall.
    logic m2_pend;
    int   m2_cnt, m2_nst;
    assign master2_waitrequest = master2_write && (m2_pend ? (m2_cnt != 0) : (m2_nst != 0));

    always @(posedge clk) begin
        if (!rst_n) begin
            m2_pend <= 1'b0; m2_cnt <= 0; m2_nst <= 0;
        end else begin
            if (master2_write) begin
                if (!m2_pend) begin
                    if (m2_nst == 0) m2_nst <= pick_stall();
                    else begin m2_pend <= 1'b1; m2_cnt <= m2_nst - 1; end
                end else if (m2_cnt == 0) begin
                    m2_pend <= 1'b0; m2_nst <= pick_stall();
                end else m2_cnt <= m2_cnt - 1;
            end
            if (master2_write && !master2_waitrequest) sram[master2_address[9:2]] <= master2_writedata;
        end
    end

    // Activity counters and request-stability monitor.
    int dot_cyc = 0, m_cyc = 0, m2_cyc = 0, swr_cyc = 0, unstable = 0;
    logic        dot_hold = 1'b0, m_hold = 1'b0, m2_hold = 1'b0;
    logic [37:0] dot_prev;
    logic [32:0] m_prev;
    logic [64:0] m2_prev;

    always @(negedge clk) begin
        if (!rst_n) begin
            dot_hold = 1'b0; m_hold = 1'b0; m2_hold = 1'b0;
        end else begin
            if (d_strobe) dot_cyc++;
            if (master_read) m_cyc++;
            if (master2_write) m2_cyc++;
            if (slave_waitrequest) swr_cyc++;
            if (dot_hold && {dot_read, dot_write, dot_address, dot_writedata} != dot_prev) unstable++;
            if (m_hold && {master_read, master_address} != m_prev) unstable++;
            if (m2_hold && {master2_write, master2_address, master2_writedata} != m2_prev) unstable++;
            dot_hold = d_strobe && dot_waitrequest;
            dot_prev = {dot_read, dot_write, dot_address, dot_writedata};
            m_hold   = master_read && master_waitrequest;
            m_prev   = {master_read, master_address};
            m2_hold  = master2_write && master2_waitrequest;
            m2_prev  = {master2_write, master2_address, master2_writedata};
        end
    end

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        int i;
        @(negedge clk);
        slave_address = a; slave_writedata = d; slave_write = 1'b1;
        for (i = 0; i < 4000 && slave_waitrequest; i++) @(negedge clk);
        if (slave_waitrequest) check_eq("cpu_write_timeout", 32'(slave_waitrequest), 32'd0);
        @(posedge clk); #1;
        slave_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        slave_address = a; slave_read = 1'b1;
        #1 d = slave_readdata;
        @(posedge clk); #1;
        slave_read = 1'b0;
    endtask

    task automatic run_job(input logic [31:0] nin, input logic [31:0] nout, input logic [31:0] relu,
                           input logic [31:0] bbase, input logic [31:0] obase, input bit wait_done);
        bit done;
        cpu_write(REG_BIAS, bbase);
        cpu_write(REG_WEIGHT, 32'h100);
        cpu_write(REG_INPUT, 32'h200);
        cpu_write(REG_OUTPUT, obase);
        cpu_write(REG_NIN, nin);
        cpu_write(REG_NOUT, nout);
        cpu_write(REG_RELU, relu);
        cpu_write(REG_CTRL, 32'd1);
        if (wait_done) begin
            done = 1'b0;
            for (int i = 0; i < 4000 && !done; i++) begin
                @(negedge clk);
                if (!slave_waitrequest) done = 1'b1;
            end
            if (!done) check_eq("job_timeout", 32'(slave_waitrequest), 32'd0);
        end
    endtask

    logic [31:0] rd;
    int          s_dot, s_m, s_m2, s_swr, s_len, s_uns;
    bit          seen;

    initial begin
        rst_n = 1'b0; slave_address = '0; slave_read = 1'b0; slave_write = 1'b0;
        slave_writedata = '0;
        for (int i = 0; i < 256; i++) begin sdram[i] = '0; sram[i] = 32'hDEADBEEF; end
        sdram[64] = 32'h0001_0000; sdram[65] = 32'h0002_0000; sdram[66] = 32'h0003_0000;
        sdram[67] = 32'hFFFF_0000; sdram[68] = 32'h0000_0000; sdram[69] = 32'h0001_0000;
        for (int i = 128; i < 131; i++) sdram[i] = 32'h0001_0000;
        sdram[192] = 32'h0000_8000; sdram[193] = 32'hFFFB_0000;
        sdram[208] = 32'h0001_0000; sdram[209] = 32'hFFFF_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        #1;
        check_eq("rst_waitreq", 32'(slave_waitrequest), 32'd0);
        check_eq("rst_strobes", 32'({dot_read, dot_write, master_read, master_write,
                                     master2_read, master2_write}), 32'd0);
        for (int a = 0; a < 8; a++) begin
            cpu_read(4'(a), rd);
            check_eq($sformatf("rst_reg%0d", a), rd, 32'd0);
        end

        // 1: plain dense layer.
        run_job(32'd3, 32'd2, 32'd0, 32'h300, 32'h000, 1'b1);
        check_eq("t1_y0", sram[0], 32'h0006_8000);
        check_eq("t1_y1", sram[1], 32'hFFFB_0000);
        cpu_read(REG_CTRL, rd);
        check_eq("t1_rows", rd, 32'd2);
        cpu_read(REG_NIN, rd);
        check_eq("t1_nin", rd, 32'd3);

        // 2: ReLU clamps the negative row.
        run_job(32'd3, 32'd2, 32'd1, 32'h300, 32'h010, 1'b1);
        check_eq("t2_y0", sram[4], 32'h0006_8000);
        check_eq("t2_y1", sram[5], 32'h0000_0000);

        // 3: n_out == 0 is a no-op.
        s_dot = dot_cyc; s_m = m_cyc; s_m2 = m2_cyc; s_swr = swr_cyc;
        run_job(32'd3, 32'd0, 32'd0, 32'h300, 32'h080, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("t3_waitreq", 32'(swr_cyc - s_swr), 32'd0);
        check_eq("t3_strobes", 32'((dot_cyc - s_dot) + (m_cyc - s_m) + (m2_cyc - s_m2)), 32'd0);
        cpu_read(REG_CTRL, rd);
        check_eq("t3_rows", rd, 32'd0);

        // 4: n_in == 0 bypasses the engine entirely.
        s_dot = dot_cyc; s_len = len_writes;
        run_job(32'd0, 32'd2, 32'd1, 32'h340, 32'h020, 1'b1);
        check_eq("t4_dot_strobes", 32'(dot_cyc - s_dot), 32'd0);
        check_eq("t4_len_writes", 32'(len_writes - s_len), 32'd0);
        check_eq("t4_y0", sram[8], 32'h0001_0000);
        check_eq("t4_y1", sram[9], 32'h0000_0000);
        cpu_read(REG_CTRL, rd);
        check_eq("t4_rows", rd, 32'd2);

        // 5: long stalls on every bus.
        stall_fixed = 5;
        s_uns = unstable;
        run_job(32'd3, 32'd2, 32'd0, 32'h300, 32'h030, 1'b1);
        check_eq("t5_unstable", 32'(unstable - s_uns), 32'd0);
        check_eq("t5_y0", sram[12], 32'h0006_8000);
        check_eq("t5_y1", sram[13], 32'hFFFB_0000);
        cpu_read(REG_CTRL, rd);
        check_eq("t5_rows", rd, 32'd2);
        stall_fixed = -1;

        // 6: reset while row 0 waits for its result.
        run_job(32'd3, 32'd2, 32'd0, 32'h300, 32'h060, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (dot_read) seen = 1'b1;
        end
        check_eq("t6_saw_result", 32'(seen), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("t6_strobes", 32'({dot_read, dot_write, master_read, master2_write}), 32'd0);
        check_eq("t6_waitreq", 32'(slave_waitrequest), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cpu_read(REG_CTRL, rd);
        check_eq("t6_rows", rd, 32'd0);
        check_eq("t6_no_write", sram[24], 32'hDEADBEEF);
        run_job(32'd3, 32'd2, 32'd0, 32'h300, 32'h040, 1'b1);
        check_eq("t6_y0", sram[16], 32'h0006_8000);
        check_eq("t6_y1", sram[17], 32'hFFFB_0000);
        cpu_read(REG_CTRL, rd);
        check_eq("t6_rows_after", rd, 32'd2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
